// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, one full-subtractor cell, LSB first
// Start/done handshake; diff/borrow hold the last completed result.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x, y, d_bit, br_next;

    always_comb begin
        x       = a_sh_q[0];
        y       = b_sh_q[0];
        d_bit   = x ^ y ^ br_q;
        br_next = (~x & y) | (~(x ^ y) & br_q);

        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                // Last bit: publish the fully shifted result together with the final borrow.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed bench for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int               n_checks;
    int               n_errors;
    logic [WIDTH-1:0] prev_diff;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    end

    // Full operation from an idle negedge; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
        logic [WIDTH-1:0] ed;
        logic             eb;
        ed    = ta - tb_v;
        eb    = (ta < tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check("busy_in_shift", {31'd0, busy}, 32'd1);
            check("no_done_in_shift", {31'd0, done}, 32'd0);
            check("diff_held", {28'd0, diff}, {28'd0, prev_diff});
            @(posedge clk);
        end
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("diff", {28'd0, diff}, {28'd0, ed});
        check("borrow", {31'd0, borrow}, {31'd0, eb});
        @(posedge clk);
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
        check("idle_not_busy", {31'd0, busy}, 32'd0);
        check("diff_hold", {28'd0, diff}, {28'd0, ed});
        prev_diff = ed;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_diff = '0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;

        // Reset
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {28'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);

        // Directed vectors
        run_op(4'd9, 4'd3);
        run_op(4'd3, 4'd9);
        run_op(4'd0, 4'd1);
        run_op(4'd5, 4'd5);
        run_op(4'd15, 4'd0);
        run_op(4'd0, 4'd15);

        // start held high, a changed mid-SHIFT; second start only after DONE->IDLE
        a     = 4'd9;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_busy0", {31'd0, busy}, 32'd1);
        a = 4'd15;
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_diff", {28'd0, diff}, 32'd6);
        @(posedge clk);
        @(negedge clk);
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        check("hold_idle_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_restart", {31'd0, busy}, 32'd1);
        start = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold2_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        check("hold2_done", {31'd0, done}, 32'd1);
        check("hold2_diff", {28'd0, diff}, 32'd12);
        check("hold2_borrow", {31'd0, borrow}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        prev_diff = 4'd12;

        // Reset on the second SHIFT cycle
        a     = 4'd9;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_diff", {28'd0, diff}, 32'd0);
        check("midrst_borrow", {31'd0, borrow}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        prev_diff = '0;
        run_op(4'd12, 4'd4);

        // Exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
